// File: rtl/register_file_mp.sv
// Multi-port integer register file with optional write-to-read bypass
// and a per-register busy scoreboard for long-latency producers.
module register_file_mp #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD*XLEN-1:0]   rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*AW-1:0]     wr_addr,
    input  logic [NUM_WR*XLEN-1:0]   wr_data,
    input  logic                     rsv_en,
    input  logic [AW-1:0]            rsv_addr,
    input  logic                     flush
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_nxt;
    logic [NREGS-1:0] wr_hit;

    always_comb begin
        wr_hit = '0;
        for (int p = 0; p < NUM_WR; p++) begin
            if (wr_en[p]) begin
                wr_hit[wr_addr[p*AW +: AW]] = 1'b1;
            end
        end
    end

    // Reservation outranks write-back: the reserving instruction is the newer producer.
    always_comb begin
        busy_nxt = busy;
        for (int r = 1; r < NREGS; r++) begin
            if (flush) begin
                busy_nxt[r] = 1'b0;
            end else if (rsv_en && rsv_addr == AW'(r)) begin
                busy_nxt[r] = 1'b1;
            end else if (wr_hit[r]) begin
                busy_nxt[r] = 1'b0;
            end
        end
        if (flush && rsv_en) begin
            busy_nxt[rsv_addr] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) begin
                regs[r] <= '0;
            end
            busy <= '0;
        end else begin
            // Later ports overwrite earlier ones, so the highest index wins.
            for (int p = 0; p < NUM_WR; p++) begin
                if (wr_en[p] && wr_addr[p*AW +: AW] != '0) begin
                    regs[wr_addr[p*AW +: AW]] <= wr_data[p*XLEN +: XLEN];
                end
            end
            busy <= busy_nxt;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
        logic            hit;
        logic            bsy;

        assign addr = rd_addr[i*AW +: AW];

        always_comb begin
            data = regs[addr];
            hit  = 1'b0;
            if (BYPASS != 0 && addr != '0) begin
                for (int p = 0; p < NUM_WR; p++) begin
                    if (wr_en[p] && wr_addr[p*AW +: AW] == addr) begin
                        data = wr_data[p*XLEN +: XLEN];
                        hit  = 1'b1;
                    end
                end
            end
            bsy = busy[addr] & ~hit;
            // Forwarded write data must not leak out while reset is held.
            if (!rst_n) begin
                data = '0;
                bsy  = 1'b0;
            end
        end

        assign rd_data[i*XLEN +: XLEN] = data;
        assign rd_busy[i]              = bsy;
    end

endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench for register_file_mp: one bypassing and one
// non-bypassing instance driven by the same stimulus.
module tb_register_file_mp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  rd_addr;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic        rsv_en;
    logic [4:0]  rsv_addr;
    logic        flush;

    logic [63:0] rdb_data;
    logic [1:0]  rdb_busy;
    logic [63:0] rdn_data;
    logic [1:0]  rdn_busy;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    register_file_mp #(.BYPASS(1)) u_byp (
        .clk(clk), .rst_n(rst_n),
        .rd_addr(rd_addr), .rd_data(rdb_data), .rd_busy(rdb_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .flush(flush)
    );

    register_file_mp #(.BYPASS(0)) u_nob (
        .clk(clk), .rst_n(rst_n),
        .rd_addr(rd_addr), .rd_data(rdn_data), .rd_busy(rdn_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .flush(flush)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en  = 2'b00;
        rsv_en = 1'b0;
        flush  = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        rd_addr  = '0;
        wr_en    = '0;
        wr_addr  = '0;
        wr_data  = '0;
        rsv_en   = 1'b0;
        rsv_addr = '0;
        flush    = 1'b0;
        tick();
        tick();
        chk("reset_rd0", rdb_data[31:0], 32'h0);
        chk("reset_busy", {30'b0, rdb_busy}, 32'h0);

        // Reset asserted in the middle of traffic
        rst_n    = 1'b1;
        rsv_en   = 1'b1;
        rsv_addr = 5'd5;
        wr_en    = 2'b11;
        wr_addr  = {5'd2, 5'd1};
        wr_data  = {32'h22, 32'h11};
        tick();
        rsv_en  = 1'b0;
        wr_data = {32'h44, 32'h33};
        rd_addr = {5'd5, 5'd1};
        #2;
        chk("pre_rst_byp_x1", rdb_data[31:0], 32'h33);
        chk("pre_rst_busy_x5", {31'b0, rdb_busy[1]}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rst_byp_d0", rdb_data[31:0], 32'h0);
        chk("rst_byp_d1", rdb_data[63:32], 32'h0);
        chk("rst_nob_d0", rdn_data[31:0], 32'h0);
        chk("rst_byp_busy", {30'b0, rdb_busy}, 32'h0);
        tick();
        chk("rst_held_d0", rdb_data[31:0], 32'h0);
        rst_n = 1'b1;
        idle();
        #1;
        chk("post_rst_x5", rdb_data[63:32], 32'h0);
        chk("post_rst_x5_busy", {31'b0, rdb_busy[1]}, 32'h0);
        chk("post_rst_x1", rdn_data[31:0], 32'h0);

        // Basic write then read, and x0 write is dropped
        wr_en   = 2'b01;
        wr_addr = {5'd0, 5'd3};
        wr_data = {32'h0, 32'hDEADBEEF};
        tick();
        idle();
        rd_addr = {5'd0, 5'd3};
        #1;
        chk("x3_byp", rdb_data[31:0], 32'hDEADBEEF);
        chk("x3_nob", rdn_data[31:0], 32'hDEADBEEF);
        wr_en   = 2'b10;
        wr_addr = {5'd0, 5'd0};
        wr_data = {32'h1234, 32'h0};
        rd_addr = {5'd0, 5'd0};
        #1;
        chk("x0_byp_same", rdb_data[31:0], 32'h0);
        tick();
        idle();
        #1;
        chk("x0_after", rdb_data[31:0], 32'h0);
        chk("x0_nob_after", rdn_data[63:32], 32'h0);

        // Same-address collision: port 1 wins
        wr_en   = 2'b11;
        wr_addr = {5'd7, 5'd7};
        wr_data = {32'h5555_FFFF, 32'hAAAA_0000};
        rd_addr = {5'd7, 5'd0};
        #1;
        chk("col_byp_same", rdb_data[63:32], 32'h5555_FFFF);
        chk("col_nob_same", rdn_data[63:32], 32'h0);
        tick();
        idle();
        #1;
        chk("col_byp_next", rdb_data[63:32], 32'h5555_FFFF);
        chk("col_nob_next", rdn_data[63:32], 32'h5555_FFFF);

        // Scoreboard reserve / write-back
        rsv_en   = 1'b1;
        rsv_addr = 5'd9;
        rd_addr  = {5'd0, 5'd9};
        #1;
        chk("rsv_same_cycle", {31'b0, rdb_busy[0]}, 32'h0);
        tick();
        idle();
        #1;
        chk("rsv_byp_busy", {31'b0, rdb_busy[0]}, 32'h1);
        chk("rsv_nob_busy", {31'b0, rdn_busy[0]}, 32'h1);
        wr_en   = 2'b01;
        wr_addr = {5'd0, 5'd9};
        wr_data = {32'h0, 32'h42};
        #1;
        chk("wb_byp_busy", {31'b0, rdb_busy[0]}, 32'h0);
        chk("wb_byp_data", rdb_data[31:0], 32'h42);
        chk("wb_nob_busy", {31'b0, rdn_busy[0]}, 32'h1);
        chk("wb_nob_data", rdn_data[31:0], 32'h0);
        tick();
        idle();
        #1;
        chk("wb_cleared", {31'b0, rdn_busy[0]}, 32'h0);
        chk("wb_data", rdn_data[31:0], 32'h42);
        rsv_en   = 1'b1;
        rsv_addr = 5'd9;
        wr_en    = 2'b10;
        wr_addr  = {5'd9, 5'd0};
        wr_data  = {32'h77, 32'h0};
        tick();
        idle();
        #1;
        chk("rsv_wb_busy", {31'b0, rdn_busy[0]}, 32'h1);
        chk("rsv_wb_data", rdn_data[31:0], 32'h77);

        // Flush with a surviving reservation
        rsv_en   = 1'b1;
        rsv_addr = 5'd4;
        tick();
        rsv_addr = 5'd6;
        tick();
        idle();
        rd_addr = {5'd6, 5'd4};
        #1;
        chk("pre_flush_x4", {31'b0, rdb_busy[0]}, 32'h1);
        chk("pre_flush_x6", {31'b0, rdb_busy[1]}, 32'h1);
        flush    = 1'b1;
        rsv_en   = 1'b1;
        rsv_addr = 5'd10;
        tick();
        idle();
        #1;
        chk("flush_x4_x6", {30'b0, rdb_busy}, 32'h0);
        rd_addr = {5'd9, 5'd10};
        #1;
        chk("flush_x10", {31'b0, rdb_busy[0]}, 32'h1);
        chk("flush_x9", {31'b0, rdn_busy[1]}, 32'h0);
        rsv_en   = 1'b1;
        rsv_addr = 5'd0;
        tick();
        idle();
        rd_addr = {5'd0, 5'd0};
        #1;
        chk("x0_busy_byp", {30'b0, rdb_busy}, 32'h0);
        chk("x0_busy_nob", {30'b0, rdn_busy}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
